// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Bit counter width; never below one bit so the counter always exists.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parametrised PISO serializer: accepts a word over valid/ready and shifts it out
// one bit per enabled cycle, MSB- or LSB-first, with gapless back-to-back words.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             lsb_first,
  input  logic             shift_en,
  input  logic             sdi,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             sdo_last
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  piso_state_t      state_r, state_nxt_s;
  logic [WIDTH-1:0] sreg_r, sreg_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             ord_r, ord_nxt_s;
  logic             accept_s;

  // The last bit with shift_en high frees the register, so a new word can land gaplessly.
  assign load_ready = !reset && ((state_r == IDLE) || ((cnt_r == CNT_ZERO) && shift_en));
  assign accept_s   = load_valid && load_ready;

  assign sdo       = ord_r ? sreg_r[0] : sreg_r[WIDTH-1];
  assign sdo_valid = (state_r == SHIFT);
  assign sdo_last  = (state_r == SHIFT) && (cnt_r == CNT_ZERO);

  // Next-state and datapath update; holding is the default.
  always_comb begin
    state_nxt_s = state_r;
    sreg_nxt_s  = sreg_r;
    cnt_nxt_s   = cnt_r;
    ord_nxt_s   = ord_r;
    if (accept_s) begin
      sreg_nxt_s  = load_data;
      ord_nxt_s   = lsb_first;
      cnt_nxt_s   = CNT_LAST;
      state_nxt_s = SHIFT;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = IDLE;
        end
        SHIFT: begin
          if (shift_en) begin
            if (cnt_r != CNT_ZERO) begin
              sreg_nxt_s = ord_r ? {sdi, sreg_r[WIDTH-1:1]} : {sreg_r[WIDTH-2:0], sdi};
              cnt_nxt_s  = cnt_r - CNT_ONE;
            end else begin
              state_nxt_s = IDLE;
            end
          end else begin
            state_nxt_s = SHIFT;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      sreg_r  <= {WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
      ord_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      sreg_r  <= sreg_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ord_r   <= ord_nxt_s;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (WIDTH = 8).
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_data;
  logic       lsb_first;
  logic       shift_en;
  logic       sdi;
  logic       sdo;
  logic       sdo_valid;
  logic       sdo_last;

  int checks = 0;
  int errors = 0;

  piso_serializer #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .lsb_first  (lsb_first),
    .shift_en   (shift_en),
    .sdi        (sdi),
    .sdo        (sdo),
    .sdo_valid  (sdo_valid),
    .sdo_last   (sdo_last)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #2;
    checks++;
    if ({sdo, sdo_valid, sdo_last, load_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 0000", {sdo, sdo_valid, sdo_last, load_ready});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, want 1", load_ready);
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] w = 8'h0F;
    @(negedge clk);
    load_data = w; lsb_first = 1'b0; shift_en = 1'b1; load_valid = 1'b1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL msb_accept_ready: got %b, want 1", load_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      checks++;
      if ({sdo, sdo_valid, sdo_last} !== {w[7-i], 1'b1, (i == 7)}) begin
        errors++;
        $display("FAIL msb_bit%0d: got sdo/valid/last %b, want %b", i,
                 {sdo, sdo_valid, sdo_last}, {w[7-i], 1'b1, (i == 7)});
      end
    end
    @(negedge clk);
    checks++;
    if ({sdo_valid, sdo_last} !== 2'b00) begin
      errors++;
      $display("FAIL msb_end_idle: got valid/last %b, want 00", {sdo_valid, sdo_last});
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w = 8'h0F;
    @(negedge clk);
    load_data = w; lsb_first = 1'b1; shift_en = 1'b1; load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      lsb_first  = 1'b0;
      checks++;
      if ({sdo, sdo_valid, sdo_last} !== {w[i], 1'b1, (i == 7)}) begin
        errors++;
        $display("FAIL lsb_bit%0d: got sdo/valid/last %b, want %b", i,
                 {sdo, sdo_valid, sdo_last}, {w[i], 1'b1, (i == 7)});
      end
    end
    @(negedge clk);
    checks++;
    if (sdo_valid !== 1'b0) begin
      errors++;
      $display("FAIL lsb_end_idle: got valid %b, want 0", sdo_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream = 16'hA53C;
    @(negedge clk);
    load_data = 8'hA5; lsb_first = 1'b0; shift_en = 1'b1; load_valid = 1'b1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_c0: got %b, want 1", load_ready);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) load_data = 8'h3C;
      if (i == 8) load_valid = 1'b0;
      checks++;
      if ({sdo, sdo_valid, sdo_last} !== {stream[15-i], 1'b1, (i == 7 || i == 15)}) begin
        errors++;
        $display("FAIL b2b_bit%0d: got sdo/valid/last %b, want %b", i,
                 {sdo, sdo_valid, sdo_last}, {stream[15-i], 1'b1, (i == 7 || i == 15)});
      end
      if (i < 15) begin
        checks++;
        if (load_ready !== (i == 7)) begin
          errors++;
          $display("FAIL b2b_ready_c%0d: got %b, want %b", i + 1, load_ready, (i == 7));
        end
      end
    end
    @(negedge clk);
    checks++;
    if (sdo_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end_idle: got valid %b, want 0", sdo_valid);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    load_data = 8'h80; lsb_first = 1'b0; shift_en = 1'b1; load_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      load_valid = 1'b0;
      shift_en   = !(c == 2 || c == 3);
      checks++;
      if ({sdo, sdo_valid, sdo_last} !== {(c == 1), 1'b1, (c == 10)}) begin
        errors++;
        $display("FAIL stall_c%0d: got sdo/valid/last %b, want %b", c,
                 {sdo, sdo_valid, sdo_last}, {(c == 1), 1'b1, (c == 10)});
      end
      if (c == 3) begin
        checks++;
        if (load_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_ready_c3: got %b, want 0", load_ready);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (sdo_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_end_idle: got valid %b, want 0", sdo_valid);
    end
  endtask

  task automatic test_sdi_fill();
    @(negedge clk);
    load_data = 8'h00; lsb_first = 1'b0; shift_en = 1'b1; sdi = 1'b1; load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      checks++;
      if ({sdo, sdo_valid} !== 2'b01) begin
        errors++;
        $display("FAIL sdi_bit%0d: got sdo/valid %b, want 01", i, {sdo, sdo_valid});
      end
    end
    @(negedge clk);
    sdi = 1'b0;
    checks++;
    if (sdo_valid !== 1'b0) begin
      errors++;
      $display("FAIL sdi_end_idle: got valid %b, want 0", sdo_valid);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w = 8'hC3;
    @(negedge clk);
    load_data = 8'hFF; lsb_first = 1'b0; shift_en = 1'b1; load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
    end
    checks++;
    if ({sdo, sdo_valid} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_before: got sdo/valid %b, want 11", {sdo, sdo_valid});
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({sdo, sdo_valid, sdo_last, load_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_async: got %b, want 0000", {sdo, sdo_valid, sdo_last, load_ready});
    end
    load_data = w; load_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (sdo_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_accept: got valid %b, want 0", sdo_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_release_ready: got %b, want 1", load_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      checks++;
      if ({sdo, sdo_valid, sdo_last} !== {w[7-i], 1'b1, (i == 7)}) begin
        errors++;
        $display("FAIL rstmid_next_bit%0d: got sdo/valid/last %b, want %b", i,
                 {sdo, sdo_valid, sdo_last}, {w[7-i], 1'b1, (i == 7)});
      end
    end
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = 8'h00;
    lsb_first = 1'b0; shift_en = 1'b0; sdi = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_stall();
    test_sdi_fill();
    test_reset_mid_word();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
